bus2_arbiter: RTL and testbench
===============================

BUS2_ARBITER -- requirements
Module: bus2_arbiter

Interface
REQ-001 Parameter A2_W, default 10, width of the bus2 line address (tag+set).
REQ-002 Parameter D2_W, default 16, width of bus2 data, two bytes per beat, little-endian (byte0 = [7:0], byte1 = [15:8]).
REQ-003 Parameter BEATS, default 8, data beats per cache line (16-byte line / 2).
REQ-004 Parameter TIMEOUT, default 255, maximum cycles spent in WAIT_RESP; range 1..255.
REQ-005 Parameter C2 codes: C2_NOP = 2'd0, C2_RESPONSE = 2'd1, C2_READ_LINE = 2'd2, C2_WRITE_LINE = 2'd3.
REQ-006 CLK  in  1  single clock; all state updates on the rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  2  per-requester line-transfer request, level, held until req_ready.
REQ-009 req_write  in  2  per requester: 1 = write line, 0 = read line.
REQ-010 req_addr  in  2*A2_W  per-requester line address; requester r occupies bits [r*A2_W +: A2_W].
REQ-011 req_wdata  in  2*D2_W  per-requester current write beat; requester r occupies bits [r*D2_W +: D2_W].
REQ-012 req_ready  out  2  one-hot, one-cycle pulse: request accepted.
REQ-013 wdata_pop  out  2  one-hot: the current write beat is consumed this cycle.
REQ-014 rdata  out  D2_W  registered read beat.
REQ-015 rdata_valid  out  2  one-hot: rdata is valid for that requester.
REQ-016 done  out  2  one-hot, one-cycle pulse: transfer finished.
REQ-017 err  out  2  one-hot, one-cycle pulse coincident with done: response timeout.
REQ-018 a2_out  out  A2_W; c2_out  out  2; d2_out  out  D2_W  bus2 drive values.
REQ-019 c2_oe, d2_oe  out  1 each  bus2 drive enables.
REQ-020 c2_in  in  2; d2_in  in  D2_W  sampled bus2 values.

Function
REQ-021 FSM states: IDLE, CMD, WBEATS, WAIT_RESP, RBEATS, DONE.
REQ-022 In IDLE, each cycle with any req_valid: grant by round-robin against last_grant; if both request, the one not equal to last_grant wins.
REQ-023 On grant: pulse req_ready[g], capture g, addr and write into registers, set last_grant = g, go to CMD; later changes on the req_* inputs of g are ignored.
REQ-024 CMD (one cycle): c2_oe = 1, a2_out = captured addr, c2_out = WRITE_LINE or READ_LINE.
REQ-025 CMD for a write additionally: d2_oe = 1, d2_out = req_wdata of g, wdata_pop[g] = 1 (beat 0); next state WBEATS.
REQ-026 CMD for a read: next state WAIT_RESP.
REQ-027 WBEATS drives beats 1..BEATS-1, one per cycle: c2_oe = 1, c2_out = C2_NOP, d2_oe = 1, wdata_pop[g] = 1; after beat BEATS-1, go to WAIT_RESP.
REQ-028 WAIT_RESP: c2_oe = d2_oe = 0; the timeout counter clears on entry and increments each cycle.
REQ-029 WAIT_RESP for a write: c2_in == C2_RESPONSE leads to DONE.
REQ-030 WAIT_RESP for a read: c2_in == C2_RESPONSE latches d2_in as beat 0 (rdata_valid[g] next cycle) and leads to RBEATS.
REQ-031 In WAIT_RESP, c2_in values other than C2_RESPONSE are ignored.
REQ-032 RBEATS latches d2_in for beats 1..BEATS-1 on consecutive cycles, each producing rdata_valid[g] the following cycle; after the last beat, go to DONE.
REQ-033 Timeout: when the counter reaches TIMEOUT with no response, go to DONE with an error flag set.
REQ-034 DONE (one cycle): done[g] = 1, err[g] = error flag; clear the flag; go to IDLE. No grant is issued in DONE.
REQ-035 c2_in is ignored outside WAIT_RESP and RBEATS.
REQ-036 Write latency: request at cycle t, then req_ready at t, CMD at t+1, last beat at t+BEATS, WAIT_RESP from t+BEATS+1.
REQ-037 Outputs not stated above are 0 in each state: c2_out = C2_NOP, a2_out = 0, d2_out = 0 when not driving.

Reset
REQ-038 While RESET is high at a clock edge: state = IDLE, last_grant = 1 (requester 0 wins the first tie), counters and flags cleared, all outputs 0.
REQ-039 Reset mid-transfer aborts the transfer: the bus is released the next cycle, and no done or err is produced.

Verification
REQ-040 Write, requester 0, addr 0x155, beats 0x0100..0x0807, response after 5 idle cycles -> C2_WRITE_LINE with a2 = 0x155 for 1 cycle, 8 data beats, oe drops, done[0] one cycle after the response, err = 0.
REQ-041 Read, requester 1, response carrying beats 0xA0A1..0xA7A8 -> rdata_valid[1] asserted for 8 consecutive cycles with those values in order, then done[1].
REQ-042 Both requesters request together, twice in sequence -> grant order is 0, 1, 0; no grant is issued during DONE.
REQ-043 Read with no response -> err[1] and done[1] pulse exactly TIMEOUT+1 cycles after WAIT_RESP entry; C2_RESPONSE injected during CMD is ignored.
REQ-044 RESET asserted at write beat 4 -> the next cycle has c2_oe = d2_oe = 0, state IDLE, no done; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/bus2_arbiter.sv
// bus2_arbiter: two-requester arbiter and sequencer for line transfers on bus2.
//
// In IDLE a requester is chosen by round-robin. The arbiter then issues one command
// cycle, streams BEATS write beats for a write, waits for C2_RESPONSE (with a timeout),
// collects BEATS read beats for a read, and finishes with a one-cycle DONE.
//
// Ports
//   CLK, RESET               clock; synchronous active-high reset
//   req_valid/write [1:0]    per-requester request level and direction (1 = write)
//   req_addr  [2*A2_W]       per-requester line address, requester r at [r*A2_W +: A2_W]
//   req_wdata [2*D2_W]       per-requester current write beat, requester r at [r*D2_W +: D2_W]
//   req_ready [1:0]          one-cycle pulse when the request is accepted
//   wdata_pop [1:0]          the current write beat is consumed this cycle
//   rdata, rdata_valid       registered read beat and its one-hot valid
//   done, err [1:0]          end-of-transfer pulse; err marks a response timeout
//   a2_out, c2_out, d2_out   bus2 drive values; c2_oe / d2_oe are their enables
//   c2_in, d2_in             sampled bus2 values
module bus2_arbiter #(
  parameter int unsigned A2_W        = 10,
  parameter int unsigned D2_W        = 16,
  parameter int unsigned BEATS       = 8,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [1:0]  C2_NOP        = 2'd0,
  parameter logic [1:0]  C2_RESPONSE   = 2'd1,
  parameter logic [1:0]  C2_READ_LINE  = 2'd2,
  parameter logic [1:0]  C2_WRITE_LINE = 2'd3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [2*A2_W-1:0] req_addr,
  input  logic [2*D2_W-1:0] req_wdata,
  output logic [1:0]        req_ready,
  output logic [1:0]        wdata_pop,
  output logic [D2_W-1:0]   rdata,
  output logic [1:0]        rdata_valid,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [A2_W-1:0]   a2_out,
  output logic [1:0]        c2_out,
  output logic [D2_W-1:0]   d2_out,
  output logic              c2_oe,
  output logic              d2_oe,
  input  logic [1:0]        c2_in,
  input  logic [D2_W-1:0]   d2_in
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWbeats,
    StWaitResp,
    StRbeats,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_q;        // granted requester index
  logic            last_q;       // last granted requester, for round-robin
  logic [A2_W-1:0] addr_q;
  logic            write_q;
  logic [BW-1:0]   beat_q;
  logic [7:0]      cnt_q;
  logic            err_q;
  logic [D2_W-1:0] rdata_q;
  logic [1:0]      rdata_valid_q;

  logic            gnt_sel;
  logic [1:0]      gnt_oh;
  logic            any_req;
  logic            resp;
  logic            last_beat;
  logic            timeout;
  logic            rd_latch;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    if (req_valid == 2'b11) begin
      gnt_sel = ~last_q;
    end else begin
      gnt_sel = req_valid[1];
    end
  end

  assign any_req   = |req_valid;
  assign gnt_oh    = gnt_q ? 2'b10 : 2'b01;
  assign resp      = (c2_in == C2_RESPONSE);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign timeout   = (cnt_q == 8'(TIMEOUT));
  assign rd_latch  = ((state_q == StWaitResp) && resp && !write_q) || (state_q == StRbeats);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) state_d = StCmd;
      end
      StCmd: begin
        if (write_q && (BEATS > 1)) state_d = StWbeats;
        else                        state_d = StWaitResp;
      end
      StWbeats: begin
        if (last_beat) state_d = StWaitResp;
      end
      StWaitResp: begin
        if (resp) begin
          if (write_q || (BEATS == 1)) state_d = StDone;
          else                         state_d = StRbeats;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StRbeats: begin
        if (last_beat) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_q         <= 1'b0;
      last_q        <= 1'b1;
      addr_q        <= '0;
      write_q       <= 1'b0;
      beat_q        <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= '0;
    end else begin
      if ((state_q == StIdle) && any_req) begin
        gnt_q   <= gnt_sel;
        last_q  <= gnt_sel;
        addr_q  <= gnt_sel ? req_addr[A2_W +: A2_W] : req_addr[0 +: A2_W];
        write_q <= req_write[gnt_sel];
      end

      // Beat 0 goes out in CMD (write) or arrives with the response (read).
      if ((state_q == StCmd) || ((state_q == StWaitResp) && resp)) begin
        beat_q <= BW'(1);
      end else if ((state_q == StWbeats) || (state_q == StRbeats)) begin
        beat_q <= beat_q + BW'(1);
      end

      // Counter is zero on the first WAIT_RESP cycle and counts up while waiting.
      cnt_q <= (state_q == StWaitResp) ? 8'(cnt_q + 8'd1) : 8'd0;

      if ((state_q == StWaitResp) && !resp && timeout) begin
        err_q <= 1'b1;
      end else if (state_q == StDone) begin
        err_q <= 1'b0;
      end

      rdata_valid_q <= rd_latch ? gnt_oh : 2'b00;
      if (rd_latch) rdata_q <= d2_in;
    end
  end

  // Outputs
  always_comb begin
    req_ready   = 2'b00;
    wdata_pop   = 2'b00;
    done        = 2'b00;
    err         = 2'b00;
    a2_out      = '0;
    c2_out      = C2_NOP;
    d2_out      = '0;
    c2_oe       = 1'b0;
    d2_oe       = 1'b0;
    rdata       = rdata_q;
    rdata_valid = rdata_valid_q;
    unique case (state_q)
      StIdle: begin
        if (any_req && !RESET) req_ready = gnt_sel ? 2'b10 : 2'b01;
      end
      StCmd: begin
        c2_oe  = 1'b1;
        a2_out = addr_q;
        c2_out = write_q ? C2_WRITE_LINE : C2_READ_LINE;
        if (write_q) begin
          d2_oe     = 1'b1;
          d2_out    = gnt_q ? req_wdata[D2_W +: D2_W] : req_wdata[0 +: D2_W];
          wdata_pop = gnt_oh;
        end
      end
      StWbeats: begin
        c2_oe     = 1'b1;
        d2_oe     = 1'b1;
        d2_out    = gnt_q ? req_wdata[D2_W +: D2_W] : req_wdata[0 +: D2_W];
        wdata_pop = gnt_oh;
      end
      StDone: begin
        done = gnt_oh;
        err  = err_q ? gnt_oh : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus2_arbiter.sv
module tb_bus2_arbiter;

  localparam int A2_W    = 10;
  localparam int D2_W    = 16;
  localparam int BEATS   = 8;
  localparam int TIMEOUT = 20;

  localparam logic [1:0] C2_NOP      = 2'd0;
  localparam logic [1:0] C2_RESPONSE = 2'd1;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [2*A2_W-1:0] req_addr;
  logic [2*D2_W-1:0] req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        wdata_pop;
  logic [D2_W-1:0]   rdata;
  logic [1:0]        rdata_valid;
  logic [1:0]        done;
  logic [1:0]        err;
  logic [A2_W-1:0]   a2_out;
  logic [1:0]        c2_out;
  logic [D2_W-1:0]   d2_out;
  logic              c2_oe;
  logic              d2_oe;
  logic [1:0]        c2_in;
  logic [D2_W-1:0]   d2_in;

  bus2_arbiter #(
    .A2_W    (A2_W),
    .D2_W    (D2_W),
    .BEATS   (BEATS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .wdata_pop   (wdata_pop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .a2_out      (a2_out),
    .c2_out      (c2_out),
    .d2_out      (d2_out),
    .c2_oe       (c2_oe),
    .d2_oe       (d2_oe),
    .c2_in       (c2_in),
    .d2_in       (d2_in)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  valid;
    logic        write;
    logic [9:0]  addr;
    int          delay;    // WAIT_RESP cycle index of the response, -1 = none
    logic        g;        // expected grant
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] wbeat(input logic g, input int k);
    return 16'h0100 + 16'(k) * 16'h0101 + (g ? 16'h1000 : 16'h0000);
  endfunction

  function automatic logic [15:0] rbeat(input int k);
    return 16'hA0A1 + 16'(k) * 16'h0101;
  endfunction

  task automatic set_wdata(input logic g, input logic [15:0] val);
    if (g) req_wdata[31:16] = val;
    else   req_wdata[15:0]  = val;
  endtask

  // Runs one transaction starting in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run_txn(input vec_t v);
    logic [1:0] oh;
    oh        = v.g ? 2'b10 : 2'b01;
    req_valid = v.valid;
    req_write = {2{v.write}};
    req_addr  = v.g ? {v.addr, ~v.addr} : {~v.addr, v.addr};
    set_wdata(v.g, wbeat(v.g, 0));
    set_wdata(~v.g, 16'hDEAD);
    @(negedge CLK);
    chk("grant_ready", {30'd0, req_ready}, {30'd0, oh});

    // CMD: the requester's inputs now change and a stray response is injected.
    next_cycle();
    req_valid = v.valid & ~oh;
    req_addr  = ~req_addr;
    req_write = ~req_write;
    c2_in     = C2_RESPONSE;
    @(negedge CLK);
    chk("cmd_c2_oe", {31'd0, c2_oe}, 32'd1);
    chk("cmd_a2", {22'd0, a2_out}, {22'd0, v.addr});
    chk("cmd_c2", {30'd0, c2_out}, v.write ? 32'd3 : 32'd2);
    chk("cmd_d2_oe", {31'd0, d2_oe}, {31'd0, v.write});
    chk("cmd_d2", {16'd0, d2_out}, v.write ? {16'd0, wbeat(v.g, 0)} : 32'd0);
    chk("cmd_pop", {30'd0, wdata_pop}, v.write ? {30'd0, oh} : 32'd0);

    if (v.write) begin
      for (int k = 1; k < BEATS; k++) begin
        next_cycle();
        c2_in = C2_NOP;
        set_wdata(v.g, wbeat(v.g, k));
        @(negedge CLK);
        chk("wbeat_d2", {16'd0, d2_out}, {16'd0, wbeat(v.g, k)});
        chk("wbeat_ctl", {26'd0, wdata_pop, c2_oe, d2_oe, c2_out},
            {26'd0, oh, 1'b1, 1'b1, C2_NOP});
      end
    end

    for (int w = 0; w <= TIMEOUT; w++) begin
      next_cycle();
      c2_in = (w == v.delay) ? C2_RESPONSE : C2_NOP;
      d2_in = rbeat(0);
      @(negedge CLK);
      chk("wait_released", {28'd0, c2_oe, d2_oe, wdata_pop}, 32'd0);
      chk("wait_no_done", {30'd0, done}, 32'd0);
      if (w == v.delay) break;
    end

    if (!v.write && v.delay >= 0) begin
      for (int k = 1; k < BEATS; k++) begin
        next_cycle();
        c2_in = C2_NOP;
        d2_in = rbeat(k);
        @(negedge CLK);
        chk("rbeat_valid", {30'd0, rdata_valid}, {30'd0, oh});
        chk("rbeat_data", {16'd0, rdata}, {16'd0, rbeat(k - 1)});
        chk("rbeat_no_done", {30'd0, done}, 32'd0);
      end
    end

    next_cycle();
    c2_in = C2_NOP;
    d2_in = '0;
    @(negedge CLK);
    chk("done", {30'd0, done}, {30'd0, oh});
    chk("err", {30'd0, err}, v.exp_err ? {30'd0, oh} : 32'd0);
    chk("done_no_grant", {30'd0, req_ready}, 32'd0);
    if (!v.write && v.delay >= 0) begin
      chk("done_rvalid", {30'd0, rdata_valid}, {30'd0, oh});
      chk("done_rdata", {16'd0, rdata}, {16'd0, rbeat(BEATS - 1)});
    end else begin
      chk("done_rvalid", {30'd0, rdata_valid}, 32'd0);
    end
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //           valid  wr    addr    delay     g     err
    vecs[0] = '{2'b01, 1'b1, 10'h155, 5,       1'b0, 1'b0};  // write, late response
    vecs[1] = '{2'b10, 1'b0, 10'h2AA, 3,       1'b1, 1'b0};  // read, requester 1
    vecs[2] = '{2'b11, 1'b1, 10'h011, 0,       1'b0, 1'b0};  // tie, last was 1
    vecs[3] = '{2'b11, 1'b1, 10'h022, 2,       1'b1, 1'b0};  // tie, last was 0
    vecs[4] = '{2'b11, 1'b0, 10'h033, 1,       1'b0, 1'b0};  // tie, last was 1
    vecs[5] = '{2'b10, 1'b0, 10'h044, -1,      1'b1, 1'b1};  // read timeout
    vecs[6] = '{2'b01, 1'b0, 10'h3FF, 0,       1'b0, 1'b0};  // immediate response
    vecs[7] = '{2'b10, 1'b1, 10'h000, TIMEOUT, 1'b1, 1'b0};  // response on last cycle

    RESET     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    c2_in     = C2_NOP;
    d2_in     = '0;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    chk("reset_ctl", {19'd0, req_ready, wdata_pop, rdata_valid, done, err, c2_oe, d2_oe, c2_out},
        32'd0);
    chk("reset_bus", {a2_out, d2_out}, 32'd0);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    next_cycle();
    RESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i]);
    end
    req_valid = '0;

    // Reset during write beat 4 aborts the transfer without done.
    next_cycle();
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {10'h000, 10'h0F0};
    set_wdata(1'b0, wbeat(1'b0, 0));
    @(negedge CLK);
    chk("rst_seq_ready", {30'd0, req_ready}, 32'd1);
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      set_wdata(1'b0, wbeat(1'b0, k));
    end
    @(negedge CLK);
    chk("rst_seq_beat4", {16'd0, d2_out}, {16'd0, wbeat(1'b0, 4)});
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_seq_released", {27'd0, c2_oe, d2_oe, wdata_pop, req_ready[0]}, 32'd0);
    chk("rst_seq_no_done", {28'd0, done, err}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge CLK);
      chk("rst_seq_quiet", {26'd0, done, err, c2_oe, d2_oe, wdata_pop}, 32'd0);
    end
    next_cycle();
    run_txn('{2'b01, 1'b1, 10'h0F0, 2, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
